// File: rtl/mining_pkg.sv
// mining_pkg: shared types, constants and byte-order helpers for the header-hash datapath
package mining_pkg;
    typedef logic [607:0] hdr_t;
    typedef logic [639:0] blk_t;
    typedef logic [255:0] hash_t;
    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, CHECK, REPORT} sched_state_t;
    localparam hash_t DIFF1_TARGET = {32'h0, 16'hFFFF, 208'h0};
    function automatic logic [31:0] byteswap32(input logic [31:0] x);
        return {x[7:0], x[15:8], x[23:16], x[31:24]};
    endfunction
    function automatic hash_t byteswap256(input hash_t x);
        hash_t y;
        for (int i = 0; i < 32; i++) y[8*i +: 8] = x[8*(31-i) +: 8];
        return y;
    endfunction
endpackage

// File: rtl/target_cmp.sv
// target_cmp: reinterprets the core digest as a little-endian number and tests it against the target
module target_cmp
    import mining_pkg::*;
(
    input  hash_t hash,
    input  hash_t target,
    output logic  hit
);
    always_comb hit = byteswap256(hash) <= target;
endmodule

// File: rtl/nonce_scheduler.sv
// nonce_scheduler: walks a nonce range through one sha256 core and reports the first hash at or below target
module nonce_scheduler
    import mining_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 4096,
    parameter logic [31:0] NONCE_STEP  = 32'd1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         cfg_valid,
    output logic         cfg_ready,
    input  logic [607:0] cfg_header,
    input  logic [31:0]  cfg_nstart,
    input  logic [31:0]  cfg_nend,
    input  logic [255:0] cfg_target,
    input  logic         abort,
    output logic         core_start,
    output logic [639:0] core_block,
    input  logic [255:0] core_hash,
    input  logic         core_done,
    output logic         res_valid,
    input  logic         res_ready,
    output logic         res_found,
    output logic [31:0]  res_nonce,
    output logic [255:0] res_hash,
    output logic         res_err,
    output logic         busy,
    output logic [31:0]  hash_count
);
    sched_state_t state;
    hdr_t         hdr;
    hash_t        target;
    hash_t        hash_q;
    logic [31:0]  nend;
    logic [31:0]  nonce;
    logic [31:0]  wdog;
    logic         abort_pend;
    logic         hit;

    target_cmp u_cmp (.hash(hash_q), .target(target), .hit(hit));

    always_comb begin
        cfg_ready  = state == IDLE;
        busy       = state != IDLE;
        core_block = {hdr, byteswap32(nonce)};
        res_nonce  = nonce;
        res_hash   = hash_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            hdr        <= '0;
            target     <= '0;
            hash_q     <= '0;
            nend       <= '0;
            nonce      <= '0;
            wdog       <= '0;
            abort_pend <= 1'b0;
            core_start <= 1'b0;
            res_valid  <= 1'b0;
            res_found  <= 1'b0;
            res_err    <= 1'b0;
            hash_count <= '0;
        end else begin
            core_start <= 1'b0;
            case (state)
                IDLE: if (cfg_valid) begin
                    hdr        <= cfg_header;
                    target     <= cfg_target;
                    nend       <= cfg_nend;
                    nonce      <= cfg_nstart;
                    hash_count <= '0;
                    res_found  <= 1'b0;
                    res_err    <= 1'b0;
                    core_start <= 1'b1;
                    state      <= ISSUE;
                end
                ISSUE: begin
                    wdog       <= '0;
                    abort_pend <= abort;
                    state      <= WAIT;
                end
                // an abort seen mid-hash is held until the core finishes so it is idle on return
                WAIT: if (core_done) begin
                    hash_q     <= core_hash;
                    hash_count <= hash_count + {31'd0, ~&hash_count};
                    res_valid  <= abort_pend | abort;
                    state      <= (abort_pend | abort) ? REPORT : CHECK;
                end else if (TIMEOUT_CYC != 0 && wdog == TIMEOUT_CYC - 1) begin
                    res_err   <= 1'b1;
                    res_valid <= 1'b1;
                    state     <= REPORT;
                end else begin
                    wdog       <= wdog + 32'd1;
                    abort_pend <= abort_pend | abort;
                end
                CHECK: if (hit || abort || nonce == nend) begin
                    res_found <= hit;
                    res_valid <= 1'b1;
                    state     <= REPORT;
                end else begin
                    nonce      <= nonce + NONCE_STEP;
                    core_start <= 1'b1;
                    state      <= ISSUE;
                end
                REPORT: if (res_ready) begin
                    res_valid <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
